// File: rtl/click_classifier.sv
// click_classifier: groups one-cycle press pulses into click gestures.
// Gestures close on a window timeout or on the final press of a gesture.
//
// Parameters:
//   WINDOW_CYCLES - max cycles after a press in which the next press
//                   joins the same gesture (must be >= 2)
//   CNT_W         - width of click_count
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   press_pulse  in   press event; every high cycle is one press
//   single_click out  one-cycle pulse, gesture of one press
//   double_click out  one-cycle pulse, gesture of two presses
//   triple_click out  one-cycle pulse, gesture of three presses
//   click_count  out  total accepted presses, modulo 2^CNT_W
//   busy         out  high while a gesture is open
//
// Optional feature macro: CLICK_TRIPLE_EN
//   Defined:   adds a third-press state and drives triple_click.
//   Undefined: two-press gestures only; triple_click is tied to 0.

module click_classifier #(
    parameter int WINDOW_CYCLES = 25000000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             press_pulse,
    output logic             single_click,
    output logic             double_click,
    output logic             triple_click,
    output logic [CNT_W-1:0] click_count,
    output logic             busy
);

    localparam int TW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        WAIT3 = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    // The last window cycle only times out when no press arrives in it;
    // a coincident press takes priority and joins the gesture.
    logic timeout;
    assign timeout = (timer == T_LAST) && !press_pulse;

`ifdef CLICK_TRIPLE_EN
    logic triple_q;
    assign triple_click = triple_q;
`else
    assign triple_click = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
            click_count  <= '0;
`ifdef CLICK_TRIPLE_EN
            triple_q     <= 1'b0;
`endif
        end else begin
            // Click outputs are pulses: cleared unless set below.
            single_click <= 1'b0;
            double_click <= 1'b0;
`ifdef CLICK_TRIPLE_EN
            triple_q     <= 1'b0;
`endif

            // Every press is counted regardless of gesture state.
            if (press_pulse) begin
                click_count <= click_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (press_pulse) begin
                        state <= WAIT2;
                        busy  <= 1'b1;
                    end
                end

                WAIT2: begin
                    if (press_pulse) begin
                        timer <= '0;
`ifdef CLICK_TRIPLE_EN
                        state <= WAIT3;
`else
                        state        <= IDLE;
                        busy         <= 1'b0;
                        double_click <= 1'b1;
`endif
                    end else if (timeout) begin
                        timer        <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        single_click <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

`ifdef CLICK_TRIPLE_EN
                WAIT3: begin
                    if (press_pulse) begin
                        timer    <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        triple_q <= 1'b1;
                    end else if (timeout) begin
                        timer        <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        double_click <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_classifier.sv
// tb_click_classifier: table-driven check of click_classifier with
// WINDOW_CYCLES=8, plus hand sequences for reset and count wrap.

module tb_click_classifier;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             press_pulse;
    logic             single_click;
    logic             double_click;
    logic             triple_click;
    logic [CNT_W-1:0] click_count;
    logic             busy;

    int n_cmp;
    int n_bad;

    click_classifier #(
        .WINDOW_CYCLES(W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .press_pulse(press_pulse),
        .single_click(single_click),
        .double_click(double_click),
        .triple_click(triple_click),
        .click_count(click_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] press;
        logic [31:0] sgl;
        logic [31:0] dbl;
        logic [31:0] tpl;
        logic [31:0] bsy;
        int          count;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] b(input int i);
        logic [31:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        press_pulse = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] outs();
        return {single_click, double_click, triple_click, busy};
    endfunction

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        press_pulse = 1'b0;

        // Cycle c: press driven during c; outputs sampled mid-cycle c.
        vecs[0] = '{"single", b(1), b(10), '0, '0, rng(2, 9), 1};
        vecs[3] = '{"held3", rng(1, 3), '0, '0, '0, '0, 3};
        vecs[4] = '{"pair4", b(1) | b(5), '0, '0, '0, '0, 2};
        vecs[2] = '{"late", b(1) | b(10), b(10) | b(19), '0, '0,
                    rng(2, 9) | rng(11, 18), 2};
`ifdef CLICK_TRIPLE_EN
        vecs[1] = '{"edge", b(1) | b(9), '0, b(18), '0, rng(2, 17), 2};
        vecs[3].tpl = b(4);
        vecs[3].bsy = rng(2, 3);
        vecs[4].dbl = b(14);
        vecs[4].bsy = rng(2, 13);
        vecs[5] = '{"triple", b(1) | b(4) | b(7), '0, '0, b(8),
                    rng(2, 7), 3};
        vecs[6] = '{"dbl_to", b(1) | b(4), '0, b(13), '0, rng(2, 12), 2};
`else
        vecs[1] = '{"edge", b(1) | b(9), '0, b(10), '0, rng(2, 9), 2};
        vecs[3].dbl = b(3);
        vecs[3].sgl = b(12);
        vecs[3].bsy = b(2) | rng(4, 11);
        vecs[4].dbl = b(6);
        vecs[4].bsy = rng(2, 5);
        vecs[5] = '{"p1_4_7", b(1) | b(4) | b(7), b(16), b(5), '0,
                    rng(2, 4) | rng(8, 15), 3};
        vecs[6] = '{"p1_4", b(1) | b(4), '0, b(5), '0, rng(2, 4), 2};
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_count", 32'(click_count), 32'h0);

        foreach (vecs[v]) begin
            do_reset();
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                check($sformatf("%s_c%0d", vecs[v].name, c), 32'(outs()),
                      32'({vecs[v].sgl[c], vecs[v].dbl[c],
                           vecs[v].tpl[c], vecs[v].bsy[c]}));
                press_pulse = vecs[v].press[c];
            end
            @(negedge clk);
            check({vecs[v].name, "_count"}, 32'(click_count),
                  32'(vecs[v].count));
        end

        // Reset mid-gesture discards it; a later press starts fresh.
        do_reset();
        @(negedge clk);
        press_pulse = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            press_pulse = 1'b0;
        end
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_outs", 32'(outs()), 32'h0);
        check("rst_mid_count", 32'(click_count), 32'h0);
        @(negedge clk);
        check("rst_mid_idle", 32'(outs()), 32'h0);
        press_pulse = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            press_pulse = 1'b0;
            check($sformatf("rst_fresh_k%0d", k), 32'(outs()),
                  32'({k == 9, 1'b0, 1'b0, k != 9}));
        end
        check("rst_fresh_count", 32'(click_count), 32'h1);

        // 256 presses: 64 two-cycle pulses then 128 single pulses.
        do_reset();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            press_pulse = 1'b1;
            @(negedge clk);
            press_pulse = 1'b1;
            @(negedge clk);
            press_pulse = 1'b0;
        end
        @(negedge clk);
        check("wrap_half", 32'(click_count), 32'd128);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            press_pulse = 1'b1;
            @(negedge clk);
            press_pulse = 1'b0;
        end
        @(negedge clk);
        check("wrap_zero", 32'(click_count), 32'd0);
        press_pulse = 1'b1;
        @(negedge clk);
        press_pulse = 1'b0;
        check("wrap_one", 32'(click_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
